// File: rtl/_muxn_arb_pkg.sv
// ---------------------------------------------------------------------------
// Shared packages for the N-channel registered multiplexer.
//
//   constants     : project-wide constants (WORD_LENGTH).
//   _muxn_arb_pkg : utilities shared by arbiters:
//                   mux_mode_t  - fixed-select vs. round-robin selection
//                   rr_pick_t   - result of a rotating priority search
//                   rr_pick()   - first set request strictly after a pointer,
//                                 wrapping modulo the active channel count
// ---------------------------------------------------------------------------
package constants;
  localparam int WORD_LENGTH = 8;
endpackage

package _muxn_arb_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_t;

  // The search function works on a fixed maximum width so one definition
  // serves every channel count from 2 to 32.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr+1, ptr+2, ... ptr+num (mod num) and return the first set bit.
  // Iterating from the farthest offset down to the nearest lets the nearest
  // hit overwrite the others, so the loop has a constant bound and no break.
  // ptr must be below num, so ptr+k never exceeds 2*num-1 and a single
  // conditional subtract replaces a modulo.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX-1:0]   req,
    input logic [RR_IDX_W-1:0] ptr,
    input int                  num
  );
    rr_pick_t r;
    int       pos;
    r = '0;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= num) begin
        pos = int'(ptr) + k;
        if (pos >= num) begin
          pos = pos - num;
        end
        if (req[pos[RR_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = pos[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/_muxn_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// _rr_pick : combinational rotating priority encoder, CH requests wide.
//
// Ports:
//   req   in  CH     request vector
//   ptr   in  SEL_W  last-served index; search starts at ptr+1 (must be < CH)
//   found out 1      at least one request is set
//   idx   out SEL_W  index of the first request after ptr (0 when !found)
// ---------------------------------------------------------------------------
module _rr_pick
  import _muxn_arb_pkg::*;
#(
  parameter int CH    = 8,
  parameter int SEL_W = $clog2(CH)
) (
  input  logic [CH-1:0]    req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(RR_MAX'(req), RR_IDX_W'(ptr), CH);
    found = pick.found;
    idx   = SEL_W'(pick.idx);
  end

endmodule

// File: rtl/_muxn_arb.sv
// ---------------------------------------------------------------------------
// _muxn_arb : registered N-channel multiplexer with valid/ready handshake on
// every channel and a single registered output stage. Selection is either an
// explicit channel index (mode = 0) or round-robin among requesters
// (mode = 1). Sustains one beat per cycle with one cycle of latency.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = fixed select, 1 = round-robin
//   sel        in   channel index used in fixed mode (>= CH grants nothing)
//   in_valid   in   CH    per-channel request
//   in_data    in   CH*n  channel i at [i*n +: n]
//   in_ready   out  CH    per-channel accept, one-hot or zero
//   out_valid  out  output register holds a beat
//   out_data   out  n     registered data
//   out_sel    out  SEL_W channel that supplied out_data
//   out_ready  in   consumer accepts the beat
//   in_last    in   CH    per-channel last-beat flag   (MUXN_LOCK_EN only)
//   out_last   out  registered last flag              (MUXN_LOCK_EN only)
//
// Build option MUXN_LOCK_EN: a beat with in_last = 0 locks the grant to its
// channel until that channel transfers a beat with in_last = 1, keeping
// multi-beat packets contiguous. Without it every beat arbitrates alone.
// ---------------------------------------------------------------------------
module _muxn_arb
  import _muxn_arb_pkg::*;
#(
  parameter int n     = constants::WORD_LENGTH,
  parameter int CH    = 8,
  parameter int SEL_W = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*n-1:0]   in_data,
  output logic [CH-1:0]     in_ready,
  output logic              out_valid,
  output logic [n-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
`ifdef MUXN_LOCK_EN
  ,
  input  logic [CH-1:0]     in_last,
  output logic              out_last
`endif
);

  // -------------------------------------------------------------------------
  // Per-channel data view
  // -------------------------------------------------------------------------
  logic [n-1:0] ch_data [CH];

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_split
      assign ch_data[gi] = in_data[gi*n +: n];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic             out_valid_reg;
  logic [n-1:0]     out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic [SEL_W-1:0] rr_ptr_reg;

  // The output register can take a new beat when empty or being drained this
  // cycle; this is what lets the stage run at full rate.
  logic load_en;
  assign load_en = !out_valid_reg || out_ready;

  // -------------------------------------------------------------------------
  // Arbitration (before any lock override)
  // -------------------------------------------------------------------------
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;

  _rr_pick #(
    .CH    (CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_reg),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // When CH is not a power of two sel can name a channel that does not
  // exist; such a select grants nothing.
  logic sel_in_range;
  assign sel_in_range = (int'(sel) < CH);

  logic             arb_valid;
  logic [SEL_W-1:0] arb_idx;

  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    if (mux_mode_t'(mode) == MUX_RR) begin
      arb_valid = rr_found;
      arb_idx   = rr_idx;
    end else if (sel_in_range) begin
      arb_valid = in_valid[sel];
      arb_idx   = sel;
    end
  end

  // -------------------------------------------------------------------------
  // Final grant, with optional packet lock
  // -------------------------------------------------------------------------
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;

`ifdef MUXN_LOCK_EN
  logic             lock_reg;
  logic [SEL_W-1:0] lock_ch_reg;
  logic             out_last_reg;

  // While a packet is open the locked channel owns the output regardless of
  // mode, sel or rr_ptr; everyone else stalls.
  always_comb begin
    grant_valid = arb_valid;
    grant_idx   = arb_idx;
    if (lock_reg) begin
      grant_valid = in_valid[lock_ch_reg];
      grant_idx   = lock_ch_reg;
    end
  end
`else
  always_comb begin
    grant_valid = arb_valid;
    grant_idx   = arb_idx;
  end
`endif

  logic         xfer;
  logic [n-1:0] grant_data;

  assign xfer       = grant_valid && load_en;
  // grant_idx is always a real channel whenever xfer is high.
  assign grant_data = ch_data[grant_idx];

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ready
      assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output register and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      // Pointing at the last channel makes channel 0 the first one searched.
      rr_ptr_reg    <= SEL_W'(CH - 1);
    end else begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= grant_data;
        out_sel_reg   <= grant_idx;
        // Tracked in fixed mode too, so switching to round-robin continues
        // fairly from whoever was served last.
        rr_ptr_reg    <= grant_idx;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef MUXN_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg     <= 1'b0;
      lock_ch_reg  <= '0;
      out_last_reg <= 1'b0;
    end else if (xfer) begin
      lock_reg     <= !in_last[grant_idx];
      lock_ch_reg  <= grant_idx;
      out_last_reg <= in_last[grant_idx];
    end
  end

  assign out_last = out_last_reg;
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule
